// File: rtl/multiciclo_ctrl_hs_pkg.sv
// Shared encodings for the handshaked multicycle RV32I controller:
// FSM states, opcodes, datapath mux selects and fault causes.
package multiciclo_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_WB_ALU    = 4'd4,
    ST_ADDR      = 4'd5,
    ST_MEM_RD    = 4'd6,
    ST_WB_MEM    = 4'd7,
    ST_MEM_WR    = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_JALR_ADDR = 4'd11,
    ST_JALR_WB   = 4'd12,
    ST_LUI       = 4'd13,
    ST_FAULT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] ORIGA_PCBACK = 2'd0;
  localparam logic [1:0] ORIGA_A      = 2'd1;
  localparam logic [1:0] ORIGA_PC     = 2'd2;
  localparam logic [1:0] ORIGA_ZERO   = 2'd3;

  localparam logic [1:0] ORIGB_B      = 2'd0;
  localparam logic [1:0] ORIGB_FOUR   = 2'd1;
  localparam logic [1:0] ORIGB_IMM    = 2'd2;

  localparam logic [1:0] M2R_ALU      = 2'd0;
  localparam logic [1:0] M2R_PC       = 2'd1;
  localparam logic [1:0] M2R_MEM      = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  function automatic logic is_req_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/multiciclo_ctrl_hs_mem_wait_timer.sv
// Counts consecutive unacknowledged memory request cycles and flags the
// cycle in which the limit is reached; a limit of 0 never expires.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (count) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Fires during the last counted cycle so the FSM can still let an ack win.
  assign expired = (TIMEOUT_CYCLES != 0) && count && (count_reg == LAST);

endmodule

// File: rtl/multiciclo_ctrl_hs.sv
// Multicycle RV32I control FSM with request/acknowledge memory handshake,
// wait-state timeout, sticky fault reporting and a retired-instruction counter.
module multiciclo_ctrl_hs
  import multiciclo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [31:0]      iInstruction,
  input  logic             iMemAck,
  output logic             oMemReq,
  output logic             oIouD,
  output logic             oLeMem,
  output logic             oEscreveMem,
  output logic             oEscreveIR,
  output logic             oEscrevePC,
  output logic             oEscrevePCCond,
  output logic             oOrigPC,
  output logic             oEscrevePCBack,
  output logic             oEscreveReg,
  output logic [1:0]       oMem2Reg,
  output logic [1:0]       oALUOp,
  output logic [1:0]       oOrigAULA,
  output logic [1:0]       oOrigBULA,
  output logic [3:0]       oEstado,
  output logic             oFault,
  output logic [1:0]       oFaultCause,
  output logic [CNT_W-1:0] oRetired
);

  state_t             state_reg, state_next;
  logic [1:0]         cause_reg, cause_next;
  logic [CNT_W-1:0]   retired_reg;
  logic               retire;
  logic               wait_cycle;
  logic               expired;
  logic [6:0]         opcode;
  logic               unused_instr_bits;

  assign opcode            = iInstruction[6:0];
  assign unused_instr_bits = ^iInstruction[31:7];
  assign wait_cycle        = is_req_state(state_reg) && !iMemAck;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (iCLK),
    .rst    (iRST),
    .clear  (!wait_cycle),
    .count  (wait_cycle),
    .expired(expired)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg   <= ST_FETCH;
      cause_reg   <= CAUSE_NONE;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      cause_reg <= cause_next;
      if (retire) begin
        retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cause_next     = cause_reg;
    retire         = 1'b0;
    oMemReq        = 1'b0;
    oIouD          = 1'b0;
    oLeMem         = 1'b0;
    oEscreveMem    = 1'b0;
    oEscreveIR     = 1'b0;
    oEscrevePC     = 1'b0;
    oEscrevePCCond = 1'b0;
    oOrigPC        = 1'b0;
    oEscrevePCBack = 1'b0;
    oEscreveReg    = 1'b0;
    oMem2Reg       = M2R_ALU;
    oALUOp         = ALUOP_ADD;
    oOrigAULA      = ORIGA_PCBACK;
    oOrigBULA      = ORIGB_B;
    oEstado        = state_reg;
    oFault         = (state_reg == ST_FAULT);
    oFaultCause    = cause_reg;
    oRetired       = retired_reg;

    case (state_reg)
      ST_FETCH: begin
        oMemReq   = 1'b1;
        oLeMem    = 1'b1;
        oOrigAULA = ORIGA_PC;
        oOrigBULA = ORIGB_FOUR;
        if (iMemAck) begin
          oEscreveIR     = 1'b1;
          oEscrevePC     = 1'b1;
          oEscrevePCBack = 1'b1;
          state_next     = ST_DECODE;
        end else if (expired) begin
          state_next = ST_FAULT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        oOrigAULA = ORIGA_PCBACK;
        oOrigBULA = ORIGB_IMM;
        case (opcode)
          OP_RTYPE:          state_next = ST_EXEC_R;
          OP_ITYPE:          state_next = ST_EXEC_I;
          OP_LOAD, OP_STORE: state_next = ST_ADDR;
          OP_BRNCH:          state_next = ST_BRANCH;
          OP_JAL:            state_next = ST_JAL;
          OP_JALR:           state_next = ST_JALR_ADDR;
          OP_LUI:            state_next = ST_LUI;
          OP_AUIPC:          state_next = ST_WB_ALU;
          default: begin
            state_next = ST_FAULT;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_EXEC_R: begin
        oOrigAULA  = ORIGA_A;
        oOrigBULA  = ORIGB_B;
        oALUOp     = ALUOP_RTYPE;
        state_next = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        oOrigAULA  = ORIGA_A;
        oOrigBULA  = ORIGB_IMM;
        oALUOp     = ALUOP_ITYPE;
        state_next = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_ALU;
        retire      = 1'b1;
        state_next  = ST_FETCH;
      end
      ST_ADDR: begin
        oOrigAULA = ORIGA_A;
        oOrigBULA = ORIGB_IMM;
        if (opcode == OP_LOAD) begin
          state_next = ST_MEM_RD;
        end else if (opcode == OP_STORE) begin
          state_next = ST_MEM_WR;
        end else begin
          state_next = ST_FAULT;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      ST_MEM_RD: begin
        oMemReq = 1'b1;
        oLeMem  = 1'b1;
        oIouD   = 1'b1;
        if (iMemAck) begin
          state_next = ST_WB_MEM;
        end else if (expired) begin
          state_next = ST_FAULT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_WB_MEM: begin
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_MEM;
        retire      = 1'b1;
        state_next  = ST_FETCH;
      end
      ST_MEM_WR: begin
        oMemReq     = 1'b1;
        oEscreveMem = 1'b1;
        oIouD       = 1'b1;
        if (iMemAck) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (expired) begin
          state_next = ST_FAULT;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      ST_BRANCH: begin
        oOrigAULA      = ORIGA_A;
        oOrigBULA      = ORIGB_B;
        oALUOp         = ALUOP_BRANCH;
        oEscrevePCCond = 1'b1;
        oOrigPC        = 1'b1;
        retire         = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_JAL, ST_JALR_WB: begin
        // PC still holds PC+4 here, so the link value and the jump share one edge.
        oEscreveReg = 1'b1;
        oMem2Reg    = M2R_PC;
        oEscrevePC  = 1'b1;
        oOrigPC     = 1'b1;
        retire      = 1'b1;
        state_next  = ST_FETCH;
      end
      ST_JALR_ADDR: begin
        oOrigAULA  = ORIGA_A;
        oOrigBULA  = ORIGB_IMM;
        state_next = ST_JALR_WB;
      end
      ST_LUI: begin
        oOrigAULA  = ORIGA_ZERO;
        oOrigBULA  = ORIGB_IMM;
        state_next = ST_WB_ALU;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_FAULT;
        cause_next = CAUSE_ILLEGAL;
      end
    endcase

    if (iRST) begin
      oMemReq        = 1'b0;
      oIouD          = 1'b0;
      oLeMem         = 1'b0;
      oEscreveMem    = 1'b0;
      oEscreveIR     = 1'b0;
      oEscrevePC     = 1'b0;
      oEscrevePCCond = 1'b0;
      oOrigPC        = 1'b0;
      oEscrevePCBack = 1'b0;
      oEscreveReg    = 1'b0;
      oMem2Reg       = 2'd0;
      oALUOp         = 2'd0;
      oOrigAULA      = 2'd0;
      oOrigBULA      = 2'd0;
      oEstado        = 4'd0;
      oFault         = 1'b0;
      oFaultCause    = 2'd0;
      oRetired       = '0;
    end
  end

endmodule

// File: tb/tb_multiciclo_ctrl_hs.sv
// Directed, table-driven bench for multiciclo_ctrl_hs: one vector per clock,
// plus a hand-written retired-counter wrap sequence.
module tb_multiciclo_ctrl_hs;

  localparam int CW = 4;

  logic          iCLK = 1'b0;
  logic          iRST = 1'b1;
  logic [31:0]   iInstruction = 32'd0;
  logic          iMemAck = 1'b0;
  logic          oMemReq, oIouD, oLeMem, oEscreveMem, oEscreveIR, oEscrevePC;
  logic          oEscrevePCCond, oOrigPC, oEscrevePCBack, oEscreveReg;
  logic [1:0]    oMem2Reg, oALUOp, oOrigAULA, oOrigBULA, oFaultCause;
  logic [3:0]    oEstado;
  logic          oFault;
  logic [CW-1:0] oRetired;

  multiciclo_ctrl_hs #(.TIMEOUT_CYCLES(16), .CNT_W(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iInstruction(iInstruction), .iMemAck(iMemAck),
    .oMemReq(oMemReq), .oIouD(oIouD), .oLeMem(oLeMem), .oEscreveMem(oEscreveMem),
    .oEscreveIR(oEscreveIR), .oEscrevePC(oEscrevePC), .oEscrevePCCond(oEscrevePCCond),
    .oOrigPC(oOrigPC), .oEscrevePCBack(oEscrevePCBack), .oEscreveReg(oEscreveReg),
    .oMem2Reg(oMem2Reg), .oALUOp(oALUOp), .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA),
    .oEstado(oEstado), .oFault(oFault), .oFaultCause(oFaultCause), .oRetired(oRetired)
  );

  always #5 iCLK = ~iCLK;

  // Enable group order: req le wr ir pc pcc origpc pcback reg
  localparam logic [8:0] EN0   = 9'b000000000;
  localparam logic [8:0] EN_FA = 9'b110110010;
  localparam logic [8:0] EN_FW = 9'b110000000;
  localparam logic [8:0] EN_WB = 9'b000000001;
  localparam logic [8:0] EN_RD = 9'b110000000;
  localparam logic [8:0] EN_WR = 9'b101000000;
  localparam logic [8:0] EN_BR = 9'b000001100;
  localparam logic [8:0] EN_J  = 9'b000010101;

  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] LW    = 32'h0000A183;
  localparam logic [31:0] ADDI  = 32'h00108093;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] AUIPC = 32'h00000097;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] JAL   = 32'h008000EF;
  localparam logic [31:0] JALR  = 32'h000080E7;
  localparam logic [31:0] SW    = 32'h0030A023;
  localparam logic [31:0] ILL   = 32'h00000000;

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] instr;
    logic [28:0] exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input int r, input int a, input logic [31:0] ins,
                              input int est, input logic [8:0] en, input int m2r,
                              input int aop, input int oa, input int ob, input int iod,
                              input int flt, input int cs, input int ret);
    vec_t v;
    v.rst   = r[0];
    v.ack   = a[0];
    v.instr = ins;
    v.exp   = {est[3:0], en, m2r[1:0], aop[1:0], oa[1:0], ob[1:0], iod[0], flt[0],
               cs[1:0], ret[CW-1:0]};
    vq.push_back(v);
  endfunction

  function automatic void rst_v();
    add(1, 1, ILL, 0, EN0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic void fa(input logic [31:0] ins, input int ret);
    add(0, 1, ins, 0, EN_FA, 0, 0, 2, 1, 0, 0, 0, ret);
  endfunction
  function automatic void fw(input logic [31:0] ins, input int ret);
    add(0, 0, ins, 0, EN_FW, 0, 0, 2, 1, 0, 0, 0, ret);
  endfunction
  function automatic void dec(input logic [31:0] ins, input int ret);
    add(0, 1, ins, 1, EN0, 0, 0, 0, 2, 0, 0, 0, ret);
  endfunction

  function automatic logic [28:0] actual();
    return {oEstado, oMemReq, oLeMem, oEscreveMem, oEscreveIR, oEscrevePC, oEscrevePCCond,
            oOrigPC, oEscrevePCBack, oEscreveReg, oMem2Reg, oALUOp, oOrigAULA, oOrigBULA,
            oIouD, oFault, oFaultCause, oRetired};
  endfunction

  task automatic step(input logic r, input logic a, input logic [31:0] ins);
    @(negedge iCLK);
    iRST = r;
    iMemAck = a;
    iInstruction = ins;
    #1;
  endtask

  initial begin
    // add with zero wait states
    rst_v();
    fa(ADD, 0); dec(ADD, 0);
    add(0, 1, ADD, 2, EN0, 0, 2, 1, 0, 0, 0, 0, 0);
    add(0, 1, ADD, 4, EN_WB, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw with three wait states in MEM_RD
    fa(LW, 1); dec(LW, 1);
    add(0, 0, LW, 5, EN0, 0, 0, 1, 2, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, LW, 6, EN_RD, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, LW, 6, EN_RD, 0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, LW, 7, EN_WB, 2, 0, 0, 0, 0, 0, 0, 1);
    // addi, lui, auipc
    fa(ADDI, 2); dec(ADDI, 2);
    add(0, 1, ADDI, 3, EN0, 0, 3, 1, 2, 0, 0, 0, 2);
    add(0, 1, ADDI, 4, EN_WB, 0, 0, 0, 0, 0, 0, 0, 2);
    fa(LUI, 3); dec(LUI, 3);
    add(0, 1, LUI, 13, EN0, 0, 0, 3, 2, 0, 0, 0, 3);
    add(0, 1, LUI, 4, EN_WB, 0, 0, 0, 0, 0, 0, 0, 3);
    fa(AUIPC, 4); dec(AUIPC, 4);
    add(0, 1, AUIPC, 4, EN_WB, 0, 0, 0, 0, 0, 0, 0, 4);
    // branch, jal, jalr
    fa(BEQ, 5); dec(BEQ, 5);
    add(0, 1, BEQ, 9, EN_BR, 0, 1, 1, 0, 0, 0, 0, 5);
    fa(JAL, 6); dec(JAL, 6);
    add(0, 1, JAL, 10, EN_J, 1, 0, 0, 0, 0, 0, 0, 6);
    fa(JALR, 7); dec(JALR, 7);
    add(0, 1, JALR, 11, EN0, 0, 0, 1, 2, 0, 0, 0, 7);
    add(0, 1, JALR, 12, EN_J, 1, 0, 0, 0, 0, 0, 0, 7);
    // sw interrupted by reset in MEM_WR, then a full store
    fa(SW, 8); dec(SW, 8);
    add(0, 0, SW, 5, EN0, 0, 0, 1, 2, 0, 0, 0, 8);
    add(0, 0, SW, 8, EN_WR, 0, 0, 0, 0, 1, 0, 0, 8);
    rst_v();
    fw(SW, 0); fa(SW, 0); dec(SW, 0);
    add(0, 0, SW, 5, EN0, 0, 0, 1, 2, 0, 0, 0, 0);
    add(0, 1, SW, 8, EN_WR, 0, 0, 0, 0, 1, 0, 0, 0);
    // illegal opcode
    fa(ILL, 1); dec(ILL, 1);
    add(0, 0, ILL, 15, EN0, 0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 1, ILL, 15, EN0, 0, 0, 0, 0, 0, 1, 1, 1);
    rst_v();
    // fetch timeout after 16 silent cycles
    for (int i = 0; i < 16; i++) fw(ADD, 0);
    add(0, 0, ADD, 15, EN0, 0, 0, 0, 0, 0, 1, 2, 0);
    add(0, 1, ADD, 15, EN0, 0, 0, 0, 0, 0, 1, 2, 0);
    rst_v();
    // ack on the 16th cycle wins over the timeout
    for (int i = 0; i < 15; i++) fw(ADD, 0);
    fa(ADD, 0); dec(ADD, 0);
    add(0, 1, ADD, 2, EN0, 0, 2, 1, 0, 0, 0, 0, 0);
    add(0, 1, ADD, 4, EN_WB, 0, 0, 0, 0, 0, 0, 0, 0);
    fw(ADD, 1);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].ack, vq[i].instr);
      n_vec++;
      if (actual() !== vq[i].exp) begin
        n_bad++;
        $display("FAIL vec%0d: state=%0d outputs=%h required state=%0d outputs=%h",
                 i, oEstado, actual(), vq[i].exp[28:25], vq[i].exp);
      end else begin
        $display("vec%0d ok state=%0d outputs=%h", i, oEstado, actual());
      end
    end

    // retired counter wraps modulo 2^CNT_W after 16 branches
    step(1'b1, 1'b0, BEQ);
    for (int k = 0; k <= 16; k++) begin
      step(1'b0, 1'b1, BEQ);
      n_vec++;
      if (oRetired !== CW'(k)) begin
        n_bad++;
        $display("FAIL wrap%0d: retired=%0d required=%0d", k, oRetired, CW'(k));
      end else begin
        $display("wrap%0d ok retired=%0d", k, oRetired);
      end
      step(1'b0, 1'b1, BEQ);
      step(1'b0, 1'b1, BEQ);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multiciclo_ctrl_hs.md
Name: multiciclo_ctrl_hs

Overview:
Parametrised multicycle RV32I control unit. It succeeds the fixed-latency multicycle controller with a request/acknowledge memory handshake, so memory may insert wait states. It adds a wait-state timeout, illegal-opcode and timeout fault detection, a gated PCBack write, LUI support and a retired-instruction counter. It drives the multicycle datapath muxes and enables; the datapath ALU control decodes ALUOp together with funct3/funct7.

Parameters:
TIMEOUT_CYCLES, 16, consecutive unacknowledged request cycles before a timeout fault; 0 disables the timeout.
CNT_W, 32, width of the retired-instruction counter.

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous reset, active-high
iInstruction  in  32  current IR contents
iMemAck  in  1  memory completed the request this cycle
oMemReq  out  1  memory request, held until acknowledged
oIouD  out  1  0 = address is PC, 1 = address is SaidaULA
oLeMem  out  1  read strobe
oEscreveMem  out  1  write strobe
oEscreveIR  out  1  IR load enable
oEscrevePC  out  1  unconditional PC write
oEscrevePCCond  out  1  PC write when ALU zero is set
oOrigPC  out  1  0 = ALU output, 1 = SaidaULA register
oEscrevePCBack  out  1  PCBack load enable
oEscreveReg  out  1  register file write
oMem2Reg  out  2  0 = ALU, 1 = PC, 2 = MemReg
oALUOp  out  2  00 = add, 01 = branch compare, 10 = R-type, 11 = I-type
oOrigAULA  out  2  0 = PCBack, 1 = A, 2 = PC, 3 = zero
oOrigBULA  out  2  0 = B, 1 = constant 4, 2 = imm
oEstado  out  4  current state encoding
oFault  out  1  sticky fault flag
oFaultCause  out  2  01 = illegal opcode, 10 = memory timeout
oRetired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: one clock; reset is synchronous and active-high (iCLK, iRST).
- While iRST is high, all outputs are 0.
- On the iRST edge: state = FETCH (0), wait counter = 0, oFault = 0, oFaultCause = 0, oRetired = 0.
- Reset mid-operation discards the in-flight instruction; no pending write completes.
- Unlisted outputs are 0 in each state. States are listed with their encoding:
  - FETCH(0): oMemReq, oLeMem; IouD = 0, OrigAULA = 2, OrigBULA = 1, ALUOp = 00. When iMemAck = 1, the same cycle also asserts oEscreveIR, oEscrevePC and oEscrevePCBack with OrigPC = 0, and the next state is DECODE. Otherwise the state stays FETCH.
  - DECODE(1): OrigAULA = 0, OrigBULA = 2, ALUOp = 00, so SaidaULA = PCBack + imm. Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> ADDR
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR_ADDR
    - 0110111 -> LUI
    - 0010111 -> WB_ALU (AUIPC)
    - any other opcode -> FAULT with cause 01
  - EXEC_R(2): OrigA = 1, OrigB = 0, ALUOp = 10; next WB_ALU.
  - EXEC_I(3): OrigA = 1, OrigB = 2, ALUOp = 11; next WB_ALU.
  - WB_ALU(4): oEscreveReg, Mem2Reg = 0; retire; next FETCH.
  - ADDR(5): OrigA = 1, OrigB = 2, ALUOp = 00; next MEM_RD for a load, MEM_WR for a store.
  - MEM_RD(6): oMemReq, oLeMem, IouD = 1; on ack -> WB_MEM.
  - WB_MEM(7): oEscreveReg, Mem2Reg = 2; retire; next FETCH.
  - MEM_WR(8): oMemReq, oEscreveMem, IouD = 1; on ack, retire and go to FETCH.
  - BRANCH(9): OrigA = 1, OrigB = 0, ALUOp = 01, oEscrevePCCond, OrigPC = 1; retire; next FETCH.
  - JAL(10): oEscreveReg, Mem2Reg = 1, oEscrevePC, OrigPC = 1 on the same edge; the register file receives the pre-edge PC (PC+4). Retire; next FETCH.
  - JALR_ADDR(11): OrigA = 1, OrigB = 2, ALUOp = 00; next JALR_WB.
  - JALR_WB(12): same outputs as JAL; retire; next FETCH.
  - LUI(13): OrigA = 3, OrigB = 2, ALUOp = 00; next WB_ALU.
  - FAULT(15): all enables 0, oFault = 1; absorbing until iRST.
- Handshake rules:
  - Request-state outputs are stable while waiting.
  - An ack in the first request cycle is legal (zero wait states).
  - iMemAck outside request states is ignored.
- Timeout:
  - The wait counter clears on entry to each request state.
  - It increments on each request cycle with iMemAck = 0.
  - The state goes to FAULT with cause 10 after exactly TIMEOUT_CYCLES unacknowledged cycles.
  - If an ack arrives in the final counted cycle, the ack wins.
- Retire: oRetired increments by 1 on the exit edge of the retiring state and wraps modulo 2^CNT_W.
- oEstado equals the state encoding; value 14 is unused, and entering it forces FAULT with cause 01.

Decomposition:
- Shared package multiciclo_pkg holds:
  - the state enum (4-bit) and opcode constants;
  - the OrigAULA, OrigBULA, Mem2Reg and ALUOp encodings;
  - the fault cause codes.
- One sub-module, mem_wait_timer (parameter TIMEOUT_CYCLES; inputs clear, count; output expired).

Test Plan:
1. iMemAck tied to 1, IR = 0x002081B3 (add x3,x1,x2) -> oEstado sequence 0,1,2,4,0; oEscreveReg = 1 only in WB_ALU; oRetired = 1 after 4 cycles.
2. lw 0x0000A183 with ack delayed 3 cycles in MEM_RD -> MEM_RD held for 4 cycles with oMemReq, IouD = 1 and oLeMem stable; then WB_MEM with Mem2Reg = 2; oRetired increments by 1.
3. TIMEOUT_CYCLES = 16, no ack in FETCH -> after 16 cycles oEstado = 15, oFault = 1, cause 10, all enables 0; iRST pulse returns to state 0 with oFault = 0. Repeat with the ack on the 16th cycle -> DECODE, no fault.
4. IR = 0x00000000 -> DECODE then FAULT, cause 01; oRetired unchanged.
5. jal 0x008000EF -> JAL cycle asserts oEscreveReg, Mem2Reg = 1, oEscrevePC, OrigPC = 1 simultaneously; oEscrevePCBack = 1 only in the FETCH ack cycle.
6. sw 0x0030A023 with iRST asserted in MEM_WR -> next state FETCH, all outputs 0 during reset, no oEscreveMem after release until the next store.
